// File: rtl/poly_synth_pwm.sv
// poly_synth_pwm: VOICES phase-accumulator square-wave voices, mixed
// into one PWM audio bit; one frame of 2**PWM_W clocks is one sample.
// Optional per-voice attack/release envelope: SYNTH_ENVELOPE_EN.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   note_value   voice v phase increment at [v*NOTE_W +: NOTE_W]
//   gate         per-voice key-down
//   audio        registered PWM output
//   sample_tick  1-clk pulse in the first cycle of each frame
//   active       voice v currently contributing to the mix
module poly_synth_pwm #(
  parameter int VOICES       = 4,
  parameter int NOTE_W       = 10,
  parameter int ACC_W        = 16,
  parameter int PWM_W        = 8,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VOICES*NOTE_W-1:0] note_value,
  input  logic [VOICES-1:0]        gate,
  output logic                     audio,
  output logic                     sample_tick,
  output logic [VOICES-1:0]        active
);

  localparam int LOG_V = $clog2(VOICES);
  localparam int SUM_W = PWM_W + LOG_V;
  localparam logic [PWM_W-1:0] MAX = '1;

  if (VOICES < 1 || VOICES > 8 ||
      (VOICES & (VOICES - 1)) != 0 ||
      ACC_W < NOTE_W ||
      ATTACK_STEP < 1 || RELEASE_STEP < 1)
  begin : g_bad_cfg
    $error("poly_synth_pwm: bad parameters");
  end

  logic [PWM_W-1:0]               pwm_cnt;
  logic [PWM_W-1:0]               pwm_cnt_next;
  logic [PWM_W-1:0]               duty;
  logic [PWM_W-1:0]               duty_next;
  logic [PWM_W-1:0]               mix;
  logic                           boundary;
  logic [VOICES-1:0]              gate_q;
  logic [VOICES*NOTE_W-1:0]       note_q;
  logic [VOICES-1:0][PWM_W-1:0]   sample;
  logic [SUM_W-1:0]               sum;

  assign boundary     = pwm_cnt == MAX;
  assign pwm_cnt_next = pwm_cnt + PWM_W'(1);
  // duty only moves on the boundary edge, so audio compares
  // against the value that will be live in the coming cycle.
  assign duty_next    = boundary ? mix : duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      sample_tick <= 1'b0;
      audio       <= 1'b0;
      duty        <= '0;
      gate_q      <= '0;
      note_q      <= '0;
    end else begin
      pwm_cnt     <= pwm_cnt_next;
      sample_tick <= boundary;
      audio       <= pwm_cnt_next < duty_next;
      duty        <= duty_next;
      if (boundary) begin
        gate_q <= gate;
        note_q <= note_value;
      end
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    logic [ACC_W-1:0] phase;
    logic [ACC_W-1:0] inc;
    logic             hi_half;

    assign inc     = ACC_W'(note_q[v*NOTE_W +: NOTE_W]);
    assign hi_half = !phase[ACC_W-1];

`ifdef SYNTH_ENVELOPE_EN
    logic [PWM_W-1:0]   level;
    logic [PWM_W-1:0]   level_up;
    logic [PWM_W-1:0]   level_dn;
    logic [PWM_W:0]     up_sum;
    logic [PWM_W-1:0]   wave;
    logic [2*PWM_W-1:0] prod;
    logic               run;

    // Oscillator keeps running through the release tail.
    assign run    = gate_q[v] | (level != '0);
    assign up_sum = {1'b0, level} + (PWM_W+1)'(ATTACK_STEP);
    assign level_up = (up_sum > {1'b0, MAX}) ? MAX
                                             : up_sum[PWM_W-1:0];
    assign level_dn = (level >= PWM_W'(RELEASE_STEP))
                    ? level - PWM_W'(RELEASE_STEP)
                    : '0;
    assign wave = hi_half ? MAX : '0;
    assign prod = (2*PWM_W)'(wave) * (2*PWM_W)'(level);
    assign sample[v] = prod[2*PWM_W-1:PWM_W];
    assign active[v] = run;

    always_ff @(posedge clk) begin
      if (rst) begin
        phase <= '0;
        level <= '0;
      end else if (boundary) begin
        phase <= run ? phase + inc : '0;
        level <= gate_q[v] ? level_up : level_dn;
      end
    end
`else
    assign sample[v] = (gate_q[v] && hi_half) ? MAX : '0;
    assign active[v] = gate_q[v];

    always_ff @(posedge clk) begin
      if (rst) begin
        phase <= '0;
      end else if (boundary) begin
        phase <= gate_q[v] ? phase + inc : '0;
      end
    end
`endif
  end

  // Sum is wide enough for VOICES full-scale samples, so the
  // shifted result never needs clipping.
  always_comb begin
    sum = '0;
    for (int v = 0; v < VOICES; v++) begin
      sum = sum + SUM_W'(sample[v]);
    end
    mix = sum[LOG_V +: PWM_W];
  end

endmodule

// File: tb/tb_poly_synth_pwm.sv
// tb_poly_synth_pwm: directed checks of poly_synth_pwm.
// Duty of a frame is measured as the audio high count over it.
module tb_poly_synth_pwm;

  localparam int V  = 4;
  localparam int NW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [V*NW-1:0] note_value;
  logic [V-1:0]    gate;
  logic            audio;
  logic            sample_tick;
  logic [V-1:0]    active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  poly_synth_pwm #(
    .VOICES(V), .NOTE_W(NW), .ACC_W(16), .PWM_W(8),
    .ATTACK_STEP(16), .RELEASE_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .note_value(note_value),
    .gate(gate),
    .audio(audio),
    .sample_tick(sample_tick),
    .active(active)
  );

  typedef struct {
    logic [V-1:0]    g;
    logic [V*NW-1:0] n;
    int              duty;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act,
                       input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance to the negedge of the next sample_tick cycle.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got none want tick");
    end
  endtask

  // Starts at the tick negedge, ends at the next one.
  task automatic measure(output int n);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      if (audio) n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    gate       = '0;
    note_value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic first_tick_after_release(input string name);
    int cnt;
    int hi;
    cnt = 0;
    hi  = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cnt++;
      if (sample_tick) break;
      if (audio) hi++;
    end
    check({name, "_first_tick"}, cnt, 256);
    check({name, "_audio_pre"}, hi, 0);
  endtask

  task automatic test_reset_hold();
    int viol;
    int n;
    rst        = 1'b1;
    gate       = 4'hF;
    note_value = '0;
    viol       = 0;
    repeat (3 * 256) begin
      @(negedge clk);
      if (audio || sample_tick || active != '0) viol++;
    end
    check("reset_hold", viol, 0);
    rst = 1'b0;
    first_tick_after_release("rel");
    check("active_e1", int'(active), 4'hF);
    measure(n);
    check("duty_e1", n, 0);
`ifndef SYNTH_ENVELOPE_EN
    measure(n);
    check("duty_e2_all", n, 255);
`endif
  endtask

`ifndef SYNTH_ENVELOPE_EN
  task automatic test_table();
    int n;
    vecs[0] = '{4'h0, 40'h0, 0};
    vecs[1] = '{4'h1, 40'h200, 63};
    vecs[2] = '{4'h3, {10'h100, 10'h100, 10'h100, 10'h100}, 127};
    vecs[3] = '{4'h7, {10'h0, 10'h155, 10'h2AA, 10'h3FF}, 191};
    vecs[4] = '{4'hF, 40'h0, 255};
    vecs[5] = '{4'h5, {10'h0, 10'h080, 10'h0, 10'h040}, 127};
    vecs[6] = '{4'h8, {10'h3FF, 30'h0}, 63};
    vecs[7] = '{4'h0, {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, 0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      gate       = vecs[i].g;
      note_value = vecs[i].n;
      wait_tick();
      check($sformatf("vec%0d_active", i), int'(active),
            int'(vecs[i].g));
      wait_tick();
      measure(n);
      check($sformatf("vec%0d_duty", i), n, vecs[i].duty);
    end
  endtask

  task automatic test_silence();
    int cnt;
    int hi;
    cnt = 0;
    hi  = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cnt++;
      if (audio) hi++;
      if (sample_tick) break;
    end
    check("tick_period", cnt, 256);
    check("silent_audio", hi, 0);
  endtask

  task automatic test_single_voice();
    int n;
    do_reset();
    gate       = 4'h1;
    note_value = 40'h200;
    wait_tick();
    wait_tick();
    measure(n);
    check("sv_frame0", n, 63);
    repeat (62) measure(n);
    measure(n);
    check("sv_frame63", n, 63);
    measure(n);
    check("sv_frame64", n, 0);
  endtask

  task automatic test_note_change();
    int n;
    do_reset();
    gate       = 4'h1;
    note_value = 40'h200;
    wait_tick();
    repeat (40) @(negedge clk);
    note_value = 40'h300;
    repeat (60) @(negedge clk);
    note_value = 40'h100;
    wait_tick();
    repeat (126) measure(n);
    measure(n);
    check("nc_frame_e128", n, 63);
    measure(n);
    check("nc_frame_e129", n, 0);
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    gate       = 4'hF;
    note_value = '0;
    wait_tick();
    wait_tick();
    repeat (100) @(negedge clk);
    check("pre_rst_audio", int'(audio), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_audio", int'(audio), 0);
    check("mid_rst_tick", int'(sample_tick), 0);
    check("mid_rst_active", int'(active), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first_tick_after_release("mid");
    measure(n);
    check("mid_duty_e1", n, 0);
    measure(n);
    check("mid_duty_e2", n, 255);
  endtask
`else
  task automatic test_envelope();
    int n;
    int ml;
    int md;
    int cur;
    bit mg;
    do_reset();
    gate       = 4'h1;
    note_value = '0;
    ml = 0;
    mg = 1'b0;
    md = 0;
    wait_tick();
    for (int f = 0; f < 100; f++) begin
      md = ((255 * ml) >> 8) >> 2;
      ml = mg ? ((ml + 16 > 255) ? 255 : ml + 16)
              : ((ml < 4) ? 0 : ml - 4);
      mg = gate[0];
      check($sformatf("env_active%0d", f), int'(active[0]),
            int'(mg || ml != 0));
      cur = md;
      md  = ((255 * ml) >> 8) >> 2;
      if (f == 20) gate = 4'h0;
      measure(n);
      check($sformatf("env_duty%0d", f), n, md);
    end
    check("env_final_level", ml, 0);
    check("env_final_active", int'(active), 0);
    if (cur < 0) $display("unreachable");
  endtask
`endif

  initial begin
    rst        = 1'b1;
    gate       = '0;
    note_value = '0;
    repeat (2) @(negedge clk);
    test_reset_hold();
`ifdef SYNTH_ENVELOPE_EN
    test_envelope();
`else
    test_table();
    test_silence();
    test_single_voice();
    test_note_change();
    test_mid_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
